// File: rtl/pipe_mem_stage_if.sv
// Bundle between the MEM stage, the EXE stage, the data memory and WB.
// master = the surrounding pipeline/memory; slave = the MEM stage itself.
interface pipe_mem_stage_if;
    // EXE -> MEM
    logic        ex_valid_i;
    logic [31:0] alu_i;
    logic [31:0] rt_i;
    logic [4:0]  rf_waddr_i;
    logic        rf_wena_i;
    logic        dmem_wena_i;
    logic        dmem_rena_i;
    logic        load_sign_i;
    logic [2:0]  load_select_i;
    logic [2:0]  store_select_i;
    logic        stall_o;
    // MEM <-> data memory
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    // MEM -> WB
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_waddr_o;
    logic        wb_wena_o;
    logic [1:0]  exc_o;

    modport master (
        output ex_valid_i, alu_i, rt_i, rf_waddr_i, rf_wena_i, dmem_wena_i, dmem_rena_i,
               load_sign_i, load_select_i, store_select_i, dmem_ack_i, dmem_rdata_i,
        input  stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
               wb_valid_o, wb_data_o, wb_waddr_o, wb_wena_o, exc_o
    );

    modport slave (
        input  ex_valid_i, alu_i, rt_i, rf_waddr_i, rf_wena_i, dmem_wena_i, dmem_rena_i,
               load_sign_i, load_select_i, store_select_i, dmem_ack_i, dmem_rdata_i,
        output stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
               wb_valid_o, wb_data_o, wb_waddr_o, wb_wena_o, exc_o
    );
endinterface

// File: rtl/pipe_mem_stage.sv
// MEM stage: req/ack data-memory access with timeout, store lane alignment, load extraction.
// Latency: 1 cycle for ALU/misaligned ops, cycles-to-ack + 2 for memory ops.
// Backpressure: stall_o holds EXE for the whole outstanding memory transaction.
module pipe_mem_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic           clk,
    input  logic           rst,
    pipe_mem_stage_if.slave bus
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [TO_W-1:0] cnt;

    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;

    logic [1:0]  off_q;
    logic        sign_q, store_q, wena_q;
    logic [2:0]  lsel_q;
    logic [4:0]  waddr_q;
    logic [31:0] alu_q;

    logic        wb_valid_q, wb_wena_q;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_waddr_q;
    logic [1:0]  exc_q;

    logic        is_store, is_mem, is_half, is_byte, misaligned;
    logic [2:0]  sel;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Decode of the instruction presented by EXE; a store takes precedence over a load.
    always_comb begin
        is_store   = bus.dmem_wena_i;
        is_mem     = bus.dmem_wena_i | bus.dmem_rena_i;
        sel        = is_store ? bus.store_select_i : bus.load_select_i;
        is_half    = (sel == 3'd1);
        is_byte    = (sel == 3'd2);
        misaligned = is_half ? bus.alu_i[0] : (!is_byte && (bus.alu_i[1:0] != 2'b00));
        st_wdata   = bus.rt_i;
        st_be      = 4'b1111;
        if (is_byte) begin
            st_wdata = {4{bus.rt_i[7:0]}};
            st_be    = 4'b0001 << bus.alu_i[1:0];
        end else if (is_half) begin
            st_wdata = {2{bus.rt_i[15:0]}};
            st_be    = bus.alu_i[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_comb begin
        ld_byte = bus.dmem_rdata_i[{off_q, 3'b000} +: 8];
        ld_half = bus.dmem_rdata_i[{off_q[1], 4'b0000} +: 16];
        case (lsel_q)
            3'd1:    ld_data = {{16{sign_q & ld_half[15]}}, ld_half};
            3'd2:    ld_data = {{24{sign_q & ld_byte[7]}}, ld_byte};
            default: ld_data = bus.dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            off_q      <= '0;
            sign_q     <= 1'b0;
            store_q    <= 1'b0;
            wena_q     <= 1'b0;
            lsel_q     <= '0;
            waddr_q    <= '0;
            alu_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_wena_q  <= 1'b0;
            wb_data_q  <= '0;
            wb_waddr_q <= '0;
            exc_q      <= 2'd0;
        end else begin
            wb_valid_q <= 1'b0;
            exc_q      <= 2'd0;
            case (state)
                IDLE: begin
                    if (bus.ex_valid_i) begin
                        alu_q   <= bus.alu_i;
                        off_q   <= bus.alu_i[1:0];
                        sign_q  <= bus.load_sign_i;
                        lsel_q  <= bus.load_select_i;
                        store_q <= is_store;
                        waddr_q <= bus.rf_waddr_i;
                        wena_q  <= bus.rf_wena_i && (bus.rf_waddr_i != 5'd0) && !is_store;
                        if (!is_mem) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= bus.alu_i;
                            wb_waddr_q <= bus.rf_waddr_i;
                            wb_wena_q  <= bus.rf_wena_i && (bus.rf_waddr_i != 5'd0);
                        end else if (misaligned) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= bus.alu_i;
                            wb_waddr_q <= bus.rf_waddr_i;
                            wb_wena_q  <= 1'b0;
                            exc_q      <= is_store ? 2'd2 : 2'd1;
                        end else begin
                            state   <= ACCESS;
                            cnt     <= '0;
                            req_q   <= 1'b1;
                            we_q    <= is_store;
                            addr_q  <= {bus.alu_i[31:2], 2'b00};
                            wdata_q <= is_store ? st_wdata : 32'd0;
                            be_q    <= is_store ? st_be : 4'b1111;
                        end
                    end
                end
                ACCESS: begin
                    // An ack arriving on the last allowed cycle still completes normally.
                    if (bus.dmem_ack_i || (cnt == TO_LAST)) begin
                        state      <= IDLE;
                        req_q      <= 1'b0;
                        we_q       <= 1'b0;
                        addr_q     <= '0;
                        wdata_q    <= '0;
                        be_q       <= '0;
                        wb_valid_q <= 1'b1;
                        wb_waddr_q <= waddr_q;
                        if (bus.dmem_ack_i) begin
                            wb_data_q <= store_q ? alu_q : ld_data;
                            wb_wena_q <= wena_q;
                        end else begin
                            wb_data_q <= alu_q;
                            wb_wena_q <= 1'b0;
                            exc_q     <= 2'd3;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall_o      = (state == ACCESS);
    assign bus.dmem_req_o   = req_q;
    assign bus.dmem_we_o    = we_q;
    assign bus.dmem_addr_o  = addr_q;
    assign bus.dmem_wdata_o = wdata_q;
    assign bus.dmem_be_o    = be_q;
    assign bus.wb_valid_o   = wb_valid_q;
    assign bus.wb_data_o    = wb_data_q;
    assign bus.wb_waddr_o   = wb_waddr_q;
    assign bus.wb_wena_o    = wb_wena_q;
    assign bus.exc_o        = exc_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Randomized scoreboard bench for pipe_mem_stage with a byte-arithmetic reference model.
module tb_pipe_mem_stage;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_mem_stage_if bus();

    pipe_mem_stage #(.TIMEOUT_CYCLES(TMO), .TO_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  waddr;
        logic        wena;
        logic [1:0]  exc;
        logic        chk_data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] s);
        if (s == 3'd1) return 2;
        if (s == 3'd2) return 1;
        return 4;
    endfunction

    // Monitor: every wb pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (bus.wb_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_wb: got wb_valid 1, expected no write-back at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_exc", 32'(bus.exc_o), 32'(e.exc));
                    check("wb_waddr", 32'(bus.wb_waddr_o), 32'(e.waddr));
                    check("wb_wena", 32'(bus.wb_wena_o), 32'(e.wena));
                    if (e.chk_data) check("wb_data", bus.wb_data_o, e.data);
                end
            end else begin
                check("exc_idle", 32'(bus.exc_o), 32'd0);
            end
        end
    end

    task automatic random_inputs(input logic vld);
        bus.ex_valid_i     = vld;
        bus.alu_i          = $urandom;
        bus.rt_i           = $urandom;
        bus.rf_waddr_i     = 5'($urandom);
        bus.rf_wena_i      = 1'($urandom);
        bus.dmem_wena_i    = 1'($urandom);
        bus.dmem_rena_i    = 1'($urandom);
        bus.load_sign_i    = 1'($urandom);
        bus.load_select_i  = 3'($urandom);
        bus.store_select_i = 3'($urandom);
    endtask

    // delay = ACCESS cycle index (from 0) carrying the ack; >= TMO means no ack.
    task automatic issue(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] wa,
                         input logic wena, input logic we, input logic re, input logic sgn,
                         input logic [2:0] lsel, input logic [2:0] ssel,
                         input int delay, input logic [31:0] rdata);
        exp_t        e;
        int          sz, off, reqc;
        logic        store, mem, mis;
        logic [63:0] v;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        store = we;
        mem   = we | re;
        sz    = size_of(store ? ssel : lsel);
        off   = int'(alu[1:0]);
        mis   = mem && ((off % sz) != 0);
        e.waddr = wa;
        e.data  = alu;
        e.exc   = 2'd0;
        e.wena  = wena && (wa != 5'd0);
        e.chk_data = 1'b0;
        if (!mem) begin
            e.chk_data = 1'b1;
        end else if (mis) begin
            e.exc  = store ? 2'd2 : 2'd1;
            e.wena = 1'b0;
        end else if (delay >= TMO) begin
            e.exc  = 2'd3;
            e.wena = 1'b0;
        end else if (store) begin
            e.wena = 1'b0;
        end else begin
            v = (64'(rdata) >> (8 * off)) & ((64'd1 << (8 * sz)) - 64'd1);
            if (sgn && sz < 4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
            e.data = v[31:0];
            e.chk_data = 1'b1;
        end
        exp_wd = (sz == 1) ? 32'(rt[7:0]) * 32'h01010101 :
                 (sz == 2) ? 32'(rt[15:0]) * 32'h00010001 : rt;
        exp_be = (sz == 1) ? 4'(1 << off) : (sz == 2) ? 4'(3 << (off & 2)) : 4'hF;

        @(posedge clk); #1;
        bus.ex_valid_i = 1'b1;  bus.alu_i = alu;  bus.rt_i = rt;
        bus.rf_waddr_i = wa;    bus.rf_wena_i = wena;
        bus.dmem_wena_i = we;   bus.dmem_rena_i = re;  bus.load_sign_i = sgn;
        bus.load_select_i = lsel;  bus.store_select_i = ssel;
        exp_q.push_back(e);
        @(posedge clk); #1;
        random_inputs(1'b0);
        if (!mem || mis) begin
            check("req_no_access", 32'(bus.dmem_req_o), 32'd0);
            check("stall_no_access", 32'(bus.stall_o), 32'd0);
        end else begin
            check("req_start", 32'(bus.dmem_req_o), 32'd1);
            check("dmem_addr", bus.dmem_addr_o, alu & 32'hFFFF_FFFC);
            check("dmem_we", 32'(bus.dmem_we_o), 32'(store));
            check("dmem_be", 32'(bus.dmem_be_o), store ? 32'(exp_be) : 32'hF);
            if (store) check("dmem_wdata", bus.dmem_wdata_o, exp_wd);
            reqc = 0;
            for (int i = 0; i < TMO; i++) begin
                if (bus.dmem_req_o === 1'b1) reqc++;
                check("stall_eq_req", 32'(bus.stall_o), 32'(bus.dmem_req_o));
                random_inputs(1'($urandom));
                if (i == delay) begin
                    bus.dmem_ack_i   = 1'b1;
                    bus.dmem_rdata_i = rdata;
                end
                @(posedge clk); #1;
                bus.dmem_ack_i   = 1'b0;
                bus.dmem_rdata_i = $urandom;
                if (i == delay) break;
            end
            bus.ex_valid_i = 1'b0;
            check("req_cycles", 32'(reqc), (delay >= TMO) ? 32'(TMO) : 32'(delay + 1));
            check("req_end", 32'(bus.dmem_req_o), 32'd0);
            check("stall_end", 32'(bus.stall_o), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(bus.stall_o), 32'd0);
        check({tag, "_req"}, 32'(bus.dmem_req_o), 32'd0);
        check({tag, "_we"}, 32'(bus.dmem_we_o), 32'd0);
        check({tag, "_addr"}, bus.dmem_addr_o, 32'd0);
        check({tag, "_wdata"}, bus.dmem_wdata_o, 32'd0);
        check({tag, "_be"}, 32'(bus.dmem_be_o), 32'd0);
        check({tag, "_wb_valid"}, 32'(bus.wb_valid_o), 32'd0);
        check({tag, "_wb_data"}, bus.wb_data_o, 32'd0);
        check({tag, "_wb_waddr"}, 32'(bus.wb_waddr_o), 32'd0);
        check({tag, "_wb_wena"}, 32'(bus.wb_wena_o), 32'd0);
        check({tag, "_exc"}, 32'(bus.exc_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        random_inputs(1'b0);
        bus.dmem_ack_i   = 1'b0;
        bus.dmem_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // ALU op, loads with sign/zero extension, half store, misaligned, timeout boundary
        issue(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 0, 32'h0);
        issue(32'h0000_0103, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 3'd0, 2, 32'h80FF_1234);
        issue(32'h0000_0103, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 3'd0, 2, 32'h80FF_1234);
        issue(32'h0000_0102, 32'hABCD_1234, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 1, 32'h0);
        issue(32'h0000_0101, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 0, 32'h0);
        issue(32'h0000_0103, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 0, 32'h0);
        issue(32'h0000_0200, 32'h5555_AAAA, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 99, 32'h0);
        issue(32'h0000_0200, 32'h5555_AAAA, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, TMO - 1, 32'h0);
        issue(32'h0000_0206, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 3'd0, 0, 32'hC001_7FFF);

        // Reset during ACCESS abandons the transaction; a late ack must be ignored.
        @(posedge clk); #1;
        bus.ex_valid_i = 1'b1;  bus.alu_i = 32'h0000_0300;  bus.rf_waddr_i = 5'd2;
        bus.rf_wena_i = 1'b1;   bus.dmem_wena_i = 1'b0;     bus.dmem_rena_i = 1'b1;
        bus.load_select_i = 3'd0;
        @(posedge clk); #1;
        bus.ex_valid_i = 1'b0;
        check("rst_pre_req", 32'(bus.dmem_req_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("mid_rst");
        bus.dmem_ack_i   = 1'b1;
        bus.dmem_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.dmem_ack_i = 1'b0;
        repeat (3) begin
            check("late_ack_req", 32'(bus.dmem_req_o), 32'd0);
            check("late_ack_stall", 32'(bus.stall_o), 32'd0);
            @(posedge clk); #1;
        end
        issue(32'hCAFE_0001, 32'h0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 0, 32'h0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int          kind, d;
            logic        we, re;
            a    = $urandom;
            kind = $urandom_range(0, 3);
            we   = (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1);
            re   = (kind == 1) || (kind == 3);
            d    = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 2, TMO + 4) : $urandom_range(0, 4);
            issue(a, $urandom, 5'($urandom), 1'($urandom), we, re, 1'($urandom),
                  3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), d, $urandom);
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
